npc_btb_predictor: RTL and testbench

Parametrised next-PC generator for the fetch stage. It holds the fetch PC register and looks up a direct-mapped branch target buffer (BTB) with saturating counters, so the next PC can be predicted in the same cycle as fetch. When a later stage resolves a control-transfer instruction, it trains the BTB; when that stage detects a misprediction, it redirects the PC. It sits between the IF-stage PC register and instruction memory, and replaces the plain PC+4/branch mux.

---
 rtl/npc_pkg.sv | 23 ++
 rtl/npc_btb_array.sv | 130 +++++++++++++
 rtl/npc_btb_predictor.sv | 64 ++++++
 tb/tb_npc_btb_predictor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC / BTB predictor: control-transfer kinds,
// default reset vector and saturating-counter reference values.
package npc_pkg;

  typedef enum logic [1:0] {
    KIND_BR  = 2'b00,
    KIND_J   = 2'b01,
    KIND_JR  = 2'b10,
    KIND_RSV = 2'b11
  } kind_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Weakly-taken is the smallest value with the counter MSB set.
  function automatic int unsigned cnt_weak_taken(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/npc_btb_array.sv
// Direct-mapped BTB storage: combinational lookup port plus a single training
// write port; the lookup always sees contents from before this cycle's update.
module npc_btb_array
  import npc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             hit_taken,
  output logic [WIDTH-1:0] hit_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [1:0]       upd_kind,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDXW - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(cnt_weak_taken(CNT_BITS));

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  kind_q;
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [IDXW-1:0] rd_idx;
  logic [TAGW-1:0] rd_tag;
  logic            rd_hit;

  logic [IDXW-1:0] wr_idx;
  logic [TAGW-1:0] wr_tag_in;
  logic            wr_hit;
  kind_e           kind;

  logic                wr_en;
  logic                wr_valid;
  logic                wr_kind;
  logic [TAGW-1:0]     wr_tag;
  logic [WIDTH-1:0]    wr_target;
  logic [CNT_BITS-1:0] wr_cnt;

  // The low two address bits never take part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_idx = lookup_pc[IDXW+1:2];
  assign rd_tag = lookup_pc[WIDTH-1:IDXW+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign hit_taken  = rd_hit && (kind_q[rd_idx] || cnt_q[rd_idx][CNT_BITS-1]);
  assign hit_target = hit_taken ? target_q[rd_idx] : '0;

  assign wr_idx    = upd_pc[IDXW+1:2];
  assign wr_tag_in = upd_pc[WIDTH-1:IDXW+2];
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag_in);
  assign kind      = kind_e'(upd_kind);

  // Build the complete replacement entry for the indexed slot; wr_en commits it.
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = valid_q[wr_idx];
    wr_kind   = kind_q[wr_idx];
    wr_tag    = tag_q[wr_idx];
    wr_target = target_q[wr_idx];
    wr_cnt    = cnt_q[wr_idx];
    if (upd_valid) begin
      case (kind)
        KIND_BR: begin
          if (wr_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
              wr_target = upd_target;
              if (cnt_q[wr_idx] != CNT_MAX) wr_cnt = cnt_q[wr_idx] + 1'b1;
            end else if (cnt_q[wr_idx] != '0) begin
              wr_cnt = cnt_q[wr_idx] - 1'b1;
            end
          end else if (upd_taken) begin
            wr_en     = 1'b1;
            wr_valid  = 1'b1;
            wr_kind   = 1'b0;
            wr_tag    = wr_tag_in;
            wr_target = upd_target;
            wr_cnt    = CNT_WEAK;
          end
        end
        KIND_J: begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_kind   = 1'b1;
          wr_tag    = wr_tag_in;
          wr_target = upd_target;
          wr_cnt    = CNT_MAX;
        end
        KIND_JR: begin
          if (wr_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      kind_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      kind_q[wr_idx]   <= wr_kind;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      cnt_q[wr_idx]    <= wr_cnt;
    end
  end

endmodule

// File: rtl/npc_btb_predictor.sv
// Fetch-stage next-PC generator: PC register, BTB lookup for same-cycle
// prediction, and the redirect/stall/predict/sequential priority mux.
module npc_btb_predictor
  import npc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int               ENTRIES  = 16,
  parameter int               CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [1:0]       upd_kind,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_seq;

  npc_btb_array #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .CNT_BITS(CNT_BITS)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lookup_pc (pc_q),
    .hit_taken (pred_taken),
    .hit_target(pred_target),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_kind  (upd_kind),
    .upd_taken (upd_taken),
    .upd_target(upd_target)
  );

  assign pc_seq = pc_q + WIDTH'(4);

  // A redirect from the resolve stage wins even over a stalled fetch.
  always_comb begin
    pc_next = pc_seq;
    if (redirect)        pc_next = redirect_pc;
    else if (stall)      pc_next = pc_q;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_next;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_npc_btb_predictor.sv
// Self-checking bench for npc_btb_predictor: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_npc_btb_predictor;

  localparam int          WIDTH    = 32;
  localparam int          ENTRIES  = 16;
  localparam int          CNT_BITS = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CMAX     = (1 << CNT_BITS) - 1;
  localparam int          CWEAK    = 1 << (CNT_BITS - 1);

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 0;

  // Behavioural model state: what the fetch PC and each BTB slot must hold.
  logic [31:0] m_pc;
  bit          m_valid  [ENTRIES];
  bit          m_uncond [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];

  npc_btb_predictor #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC),
    .ENTRIES (ENTRIES),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_kind   (upd_kind),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .pc         (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] a);
    return int'((a / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] a);
    return a / (4 * ENTRIES);
  endfunction

  function automatic bit mHit(input logic [31:0] a);
    return m_valid[midx(a)] && (m_tag[midx(a)] == mtag(a));
  endfunction

  function automatic bit mPredTaken();
    return mHit(m_pc) && (m_uncond[midx(m_pc)] || (m_cnt[midx(m_pc)] >= CWEAK));
  endfunction

  function automatic logic [31:0] mPredTarget();
    return mPredTaken() ? m_target[midx(m_pc)] : 32'h0;
  endfunction

  task automatic modelReset();
    m_pc = RESET_PC;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_uncond[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic modelAllocate(input int i, input bit uncond, input int cnt);
    m_valid[i]  = 1;
    m_uncond[i] = uncond;
    m_tag[i]    = mtag(upd_pc);
    m_target[i] = upd_target;
    m_cnt[i]    = cnt;
  endtask

  // One clock edge of the model: next PC from pre-edge state, then training.
  task automatic modelStep();
    logic [31:0] nxt;
    int          i;
    bit          hit;
    if (redirect)          nxt = redirect_pc;
    else if (stall)        nxt = m_pc;
    else if (mPredTaken()) nxt = mPredTarget();
    else                   nxt = m_pc + 32'd4;
    i   = midx(upd_pc);
    hit = mHit(upd_pc);
    if (upd_valid) begin
      case (upd_kind)
        2'b00: begin
          if (hit && upd_taken) begin
            m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
            m_target[i] = upd_target;
          end else if (hit) begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          end else if (upd_taken) begin
            modelAllocate(i, 0, CWEAK);
          end
        end
        2'b01: modelAllocate(i, 1, CMAX);
        2'b10: if (hit) m_valid[i] = 0;
        default: ;
      endcase
    end
    m_pc = nxt;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("model_pc", pc, m_pc);
    checkVal("model_pred_taken", {31'd0, pred_taken}, {31'd0, mPredTaken()});
    checkVal("model_pred_target", pred_target, mPredTarget());
  endtask

  always @(negedge clk) if (check_en) checkOutput();

  task automatic applyStimulus(input bit stl, input bit red, input logic [31:0] rpc,
                               input bit uv, input logic [1:0] uk, input logic [31:0] upc,
                               input bit ut, input logic [31:0] utgt);
    stall = stl; redirect = red; redirect_pc = rpc;
    upd_valid = uv; upd_kind = uk; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    @(posedge clk);
    if (!reset) modelStep();
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 0, 2'b00, 32'h0, 0, 32'h0);
  endtask

  // Asynchronous reset asserted between edges, whatever the inputs are doing.
  task automatic doReset();
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkVal("reset_pc", pc, 32'h0000_3000);
    checkVal("reset_pred_taken", {31'd0, pred_taken}, 32'h0);
    checkVal("reset_pred_target", pred_target, 32'h0);
    #20;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randPc();
    return 32'h3000 + 32'(4 * $urandom_range(0, 47));
  endfunction

  initial begin
    reset = 1'b1;
    stall = 0; redirect = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_kind = 0; upd_taken = 0; upd_target = 0;
    modelReset();
    check_en = 1;
    #1;
    checkVal("por_pc", pc, 32'h0000_3000);
    checkVal("por_pred_taken", {31'd0, pred_taken}, 32'h0);
    #21;
    reset = 1'b0;

    // Sequential fetch, then reset mid-run at 0x3010.
    repeat (4) idle();
    checkVal("seq_pc_3010", pc, 32'h0000_3010);
    doReset();
    repeat (3) idle();
    checkVal("post_reset_pc_300c", pc, 32'h0000_300C);

    // Conditional branch training at 0x3008 -> 0x3020.
    applyStimulus(0, 1, 32'h3008, 1, 2'b00, 32'h3008, 1, 32'h3020);
    checkVal("br_pc", pc, 32'h3008);
    checkVal("br_pred_taken", {31'd0, pred_taken}, 32'h1);
    checkVal("br_pred_target", pred_target, 32'h3020);
    applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3008, 0, 32'h0);
    applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3008, 0, 32'h0);
    checkVal("br_nt_pc_hold", pc, 32'h3008);
    checkVal("br_nt_pred_taken", {31'd0, pred_taken}, 32'h0);
    idle();
    checkVal("br_nt_fallthrough", pc, 32'h300C);

    // Counter saturation: 5 taken then 1 not-taken stays taken.
    repeat (5) applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3008, 1, 32'h3020);
    applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3008, 0, 32'h0);
    checkVal("model_cnt_after_sat", 32'(m_cnt[2]), 32'd2);
    applyStimulus(0, 1, 32'h3008, 0, 2'b00, 32'h0, 0, 32'h0);
    checkVal("sat_pred_taken", {31'd0, pred_taken}, 32'h1);
    checkVal("sat_pred_target", pred_target, 32'h3020);

    // Direct jump allocation, then indirect update invalidates it.
    applyStimulus(0, 1, 32'h3004, 1, 2'b01, 32'h3004, 0, 32'h3100);
    checkVal("j_pred_taken", {31'd0, pred_taken}, 32'h1);
    checkVal("j_pred_target", pred_target, 32'h3100);
    applyStimulus(1, 0, 32'h0, 1, 2'b10, 32'h3004, 1, 32'h3500);
    checkVal("jr_invalidated", {31'd0, pred_taken}, 32'h0);
    idle();
    checkVal("jr_fallthrough", pc, 32'h3008);

    // Redirect beats stall; stall alone holds.
    applyStimulus(1, 1, 32'h3040, 0, 2'b00, 32'h0, 0, 32'h0);
    checkVal("redirect_over_stall", pc, 32'h3040);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 32'h0, 0, 2'b00, 32'h0, 0, 32'h0);
      checkVal("stall_hold", pc, 32'h3040);
    end

    // Aliasing: 0x3000 and 0x3040 share index 0.
    applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3000, 1, 32'h3200);
    applyStimulus(1, 0, 32'h0, 1, 2'b00, 32'h3040, 1, 32'h3300);
    checkVal("alias_new_hit", pred_target, 32'h3300);
    applyStimulus(0, 1, 32'h3000, 0, 2'b00, 32'h0, 0, 32'h0);
    checkVal("alias_evicted", {31'd0, pred_taken}, 32'h0);

    // PC wraps modulo 2^32.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 2'b00, 32'h0, 0, 32'h0);
    checkVal("wrap_pc_top", pc, 32'hFFFF_FFFC);
    idle();
    checkVal("wrap_pc_zero", pc, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] rpc;
      rpc = randPc();
      if ($urandom_range(0, 15) == 0) rpc = rpc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, rpc,
                    $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), randPc(),
                    $urandom_range(0, 2) != 0, randPc());
      if (n == 750) doReset();
    end

    @(negedge clk);
    #1;
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
